// File: rtl/fpioa_pkg.sv
// -----------------------------------------------------------------------------
// fpioa_pkg
// Shared definitions for the FPIOA configuration-port arbiter:
//   - state_t      : sequencer states (IDLE -> ISSUE -> RESP)
//   - M0 / M1      : master identifiers used for grants and the rr pointer
//   - *_DEF        : default values for the top-level parameters
// -----------------------------------------------------------------------------
package fpioa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 32;
  localparam int LOCK_MAX_DEF = 64;

endpackage

// File: rtl/fpioa_rr_arb.sv
// -----------------------------------------------------------------------------
// fpioa_rr_arb
// Two-way round-robin grant. The requests arrive already masked by the
// caller's eligibility rules. On a tie the master not granted last wins.
// The pointer moves only when the caller takes the grant.
//   clk, rst   : clock, asynchronous active-high reset
//   req[1:0]   : eligible requests, bit index = master id
//   arb_en     : caller is at an arbitration point and will take the grant
//   gnt_valid  : at least one eligible request
//   gnt_id     : id of the winning master (valid with gnt_valid)
// -----------------------------------------------------------------------------
module fpioa_rr_arb
  import fpioa_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       arb_en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Id of the master granted most recently; resets to M1 so M0 wins the
  // first tie.
  logic last_q;

  always_comb begin
    gnt_valid = |req;
    gnt_id    = M0;
    if (req == 2'b11) begin
      gnt_id = ~last_q;
    end else if (req[1]) begin
      gnt_id = M1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= M1;
    end else if (arb_en && gnt_valid) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/fpioa_bus_arb.sv
// -----------------------------------------------------------------------------
// fpioa_bus_arb
// Shares the FPIOA configuration/register port between the core load/store
// path (m0) and a debug/boot pin-mux loader (m1). Each access runs as
// ISSUE (one strobe cycle) followed by RESP (ack plus registered read data).
// m1 may hold a bounded lock so that a multi-register reconfiguration is
// applied atomically.
//   clk, rst                 : clock, asynchronous active-high reset
//   mX_req_i/we_i/addr_i/
//   mX_wdata_i/sel_i         : master X request, held until mX_ack_o
//   mX_ack_o, mX_rdata_o     : one-cycle completion, read data (0 for writes)
//   m1_lock_i                : m1 asks for exclusive ownership
//   lock_to_o                : one-cycle pulse when the lock is forcibly released
//   f_waddr_o/f_raddr_o/
//   f_data_o/f_sel_o         : FPIOA address/data, hold the last latched values
//   f_we_o/f_rd_o            : FPIOA strobes, high only during ISSUE
//   f_rdata_i                : FPIOA read data, valid the cycle after f_rd_o
// -----------------------------------------------------------------------------
module fpioa_bus_arb
  import fpioa_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  output logic                m0_ack_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  output logic                m1_ack_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  input  logic                m1_lock_i,
  output logic                lock_to_o,
  output logic [ADDR_W-1:0]   f_waddr_o,
  output logic [ADDR_W-1:0]   f_raddr_o,
  output logic [DATA_W-1:0]   f_data_o,
  output logic [DATA_W/8-1:0] f_sel_o,
  output logic                f_we_o,
  output logic                f_rd_o,
  input  logic [DATA_W-1:0]   f_rdata_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  state_t state_q, state_d;

  // Transaction captured at grant.
  logic              cur_id_q;
  logic              cur_we_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [DATA_W-1:0] cur_wdata_q;
  logic [SEL_W-1:0]  cur_sel_q;

  // Lock bookkeeping.
  logic             lock_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic             lock_to_q;
  logic             lock_block_q;  // timed-out lock request not yet seen low

  logic       arb_pt;
  logic       lock_release;
  logic       lock_active;
  logic       lock_set;
  logic       timeout;
  logic [1:0] elig;
  logic       gnt_valid;
  logic       gnt_id;
  logic       take;

  // Grants are taken in IDLE and in RESP (the back-to-back path).
  assign arb_pt = (state_q == ST_IDLE) || (state_q == ST_RESP);

  // Dropping m1_lock_i at an arbitration point releases the lock in that
  // same cycle, so m0 can win the grant immediately.
  assign lock_release = lock_q && arb_pt && !m1_lock_i;
  assign lock_active  = lock_q && !lock_release;
  assign timeout      = lock_q && (lock_cnt_q == CNT_LAST);

  // The master being acked cannot be re-granted in its own RESP cycle.
  assign elig[0] = m0_req_i && !lock_active &&
                   !((state_q == ST_RESP) && (cur_id_q == M0));
  assign elig[1] = m1_req_i &&
                   !((state_q == ST_RESP) && (cur_id_q == M1));

  fpioa_rr_arb u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (elig),
    .arb_en    (arb_pt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign take     = arb_pt && gnt_valid;
  assign lock_set = take && (gnt_id == M1) && m1_lock_i && !lock_block_q;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (take) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = take ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the capture registers drive the FPIOA address/data pins directly,
  // so they are reset to give all-zero outputs out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_id_q    <= M0;
      cur_we_q    <= 1'b0;
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      cur_sel_q   <= '0;
    end else if (take) begin
      cur_id_q    <= gnt_id;
      cur_we_q    <= (gnt_id == M1) ? m1_we_i    : m0_we_i;
      cur_addr_q  <= (gnt_id == M1) ? m1_addr_i  : m0_addr_i;
      cur_wdata_q <= (gnt_id == M1) ? m1_wdata_i : m0_wdata_i;
      cur_sel_q   <= (gnt_id == M1) ? m1_sel_i   : m0_sel_i;
    end
  end

  // Lock: the timeout outranks a voluntary release. A re-grant to m1 with
  // the lock still held keeps the counter running, so the hold stays bounded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_cnt_q   <= '0;
      lock_to_q    <= 1'b0;
      lock_block_q <= 1'b0;
    end else begin
      lock_to_q <= timeout;

      if (timeout || lock_release) begin
        lock_q     <= 1'b0;
        lock_cnt_q <= '0;
      end else if (lock_q) begin
        lock_cnt_q <= lock_cnt_q + 1'b1;
      end else if (lock_set) begin
        lock_q <= 1'b1;
      end

      if (timeout) begin
        lock_block_q <= 1'b1;
      end else if (!m1_lock_i) begin
        lock_block_q <= 1'b0;
      end
    end
  end

  // Strobes and acks decode straight from the state register, so an
  // asynchronous reset removes them at once.
  assign f_we_o = (state_q == ST_ISSUE) &&  cur_we_q;
  assign f_rd_o = (state_q == ST_ISSUE) && !cur_we_q;

  // The FPIOA read path decodes waddr bits, so both addresses carry it.
  assign f_waddr_o = cur_addr_q;
  assign f_raddr_o = cur_addr_q;
  assign f_data_o  = cur_wdata_q;
  assign f_sel_o   = cur_sel_q;

  assign m0_ack_o   = (state_q == ST_RESP) && (cur_id_q == M0);
  assign m1_ack_o   = (state_q == ST_RESP) && (cur_id_q == M1);
  assign m0_rdata_o = (m0_ack_o && !cur_we_q) ? f_rdata_i : '0;
  assign m1_rdata_o = (m1_ack_o && !cur_we_q) ? f_rdata_i : '0;
  assign lock_to_o  = lock_to_q;

endmodule

// File: tb/tb_fpioa_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_fpioa_bus_arb
// Directed bench for fpioa_bus_arb. A small FPIOA read model answers reads
// one cycle after f_rd_o. Every request the bench drives pushes its expected
// completion (master id, read data) onto a queue. A negedge monitor pops that
// queue on every ack. The directed steps check strobes, addresses and ack
// timing cycle by cycle.
// -----------------------------------------------------------------------------
module tb_fpioa_bus_arb;
  import fpioa_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int LM = 16;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [SW-1:0] m0_sel, m1_sel;
  logic          m0_ack_o, m1_ack_o, lock_to_o, f_we_o, f_rd_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o, f_data_o;
  logic [AW-1:0] f_waddr_o, f_raddr_o;
  logic [SW-1:0] f_sel_o;
  logic [DW-1:0] f_rdata_i = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  fpioa_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req_i   (m0_req),
    .m0_we_i    (m0_we),
    .m0_addr_i  (m0_addr),
    .m0_wdata_i (m0_wdata),
    .m0_sel_i   (m0_sel),
    .m0_ack_o   (m0_ack_o),
    .m0_rdata_o (m0_rdata_o),
    .m1_req_i   (m1_req),
    .m1_we_i    (m1_we),
    .m1_addr_i  (m1_addr),
    .m1_wdata_i (m1_wdata),
    .m1_sel_i   (m1_sel),
    .m1_ack_o   (m1_ack_o),
    .m1_rdata_o (m1_rdata_o),
    .m1_lock_i  (m1_lock),
    .lock_to_o  (lock_to_o),
    .f_waddr_o  (f_waddr_o),
    .f_raddr_o  (f_raddr_o),
    .f_data_o   (f_data_o),
    .f_sel_o    (f_sel_o),
    .f_we_o     (f_we_o),
    .f_rd_o     (f_rd_o),
    .f_rdata_i  (f_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fpioa_val(input logic [AW-1:0] a);
    return (a == 8'h24) ? 32'hA5A5_0001 : {24'hC0DE00, a};
  endfunction

  // Registered FPIOA read port.
  always @(posedge clk) begin
    if (f_rd_o) f_rdata_i <= fpioa_val(f_raddr_o);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [DW-1:0] rdata);
    exp_t e;
    e.id    = id;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every ack must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && (m0_ack_o || m1_ack_o)) begin
      exp_t e;
      check("ack_onehot", 64'(m0_ack_o & m1_ack_o), 64'd0);
      check("ack_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_id", 64'(m1_ack_o), 64'(e.id));
        check("sb_rdata", 64'(m1_ack_o ? m1_rdata_o : m0_rdata_o), 64'(e.rdata));
      end
    end
  end

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_sel = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_sel = '0;
    m1_lock = 0;

    // Reset state.
    #1;
    check("rst_outs", 64'({m0_ack_o, m1_ack_o, lock_to_o, f_we_o, f_rd_o}), 64'd0);
    check("rst_fdata", 64'({f_waddr_o, f_raddr_o, f_data_o, f_sel_o}), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_outs", 64'({m0_ack_o, m1_ack_o, f_we_o, f_rd_o}), 64'd0);

    // m0 write 0x28; req dropped right after grant.
    m0_req = 1; m0_we = 1; m0_addr = 8'h28; m0_wdata = 32'h0000_00FF; m0_sel = 4'hF;
    push(M0, '0);
    tick();
    check("wr_issue_we", 64'(f_we_o), 64'd1);
    check("wr_issue_rd", 64'(f_rd_o), 64'd0);
    check("wr_issue_waddr", 64'(f_waddr_o), 64'h28);
    check("wr_issue_raddr", 64'(f_raddr_o), 64'h28);
    check("wr_issue_data", 64'({f_data_o, f_sel_o}), 64'h0000_00FF_F);
    check("wr_issue_noack", 64'(m0_ack_o), 64'd0);
    m0_req = 0;
    tick();
    check("wr_resp_ack", 64'(m0_ack_o), 64'd1);
    check("wr_resp_rdata", 64'(m0_rdata_o), 64'd0);
    check("wr_resp_strobes", 64'({f_we_o, f_rd_o}), 64'd0);
    check("wr_resp_hold_addr", 64'(f_waddr_o), 64'h28);
    tick();
    check("wr_after_ack", 64'(m0_ack_o), 64'd0);

    // m1 read 0x24.
    m1_req = 1; m1_we = 0; m1_addr = 8'h24; m1_sel = 4'hF;
    push(M1, 32'hA5A5_0001);
    tick();
    check("rd_issue_rd", 64'(f_rd_o), 64'd1);
    check("rd_issue_we", 64'(f_we_o), 64'd0);
    check("rd_issue_addrs", 64'({f_raddr_o, f_waddr_o}), 64'h2424);
    m1_req = 0;
    tick();
    check("rd_resp_ack", 64'({m1_ack_o, m0_ack_o}), 64'b10);
    check("rd_resp_rdata", 64'(m1_rdata_o), 64'hA5A5_0001);
    tick();

    // Both masters hold req: m0,m1,m0,m1 back to back.
    m0_req = 1; m0_we = 1; m0_addr = 8'h10; m0_wdata = 32'h11;
    m1_req = 1; m1_we = 1; m1_addr = 8'h14; m1_wdata = 32'h22;
    push(M0, '0); push(M1, '0); push(M0, '0); push(M1, '0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("rr_m0_ack_c%0d", k), 64'(m0_ack_o), 64'(k == 2 || k == 6));
      check($sformatf("rr_m1_ack_c%0d", k), 64'(m1_ack_o), 64'(k == 4 || k == 8));
      if (k % 2 == 1)
        check($sformatf("rr_issue_addr_c%0d", k), 64'(f_waddr_o),
              (k == 1 || k == 5) ? 64'h10 : 64'h14);
      if (k == 7) m0_req = 0;
      if (k == 8) m1_req = 0;
    end
    tick();
    check("rr_idle", 64'({m0_ack_o, m1_ack_o, f_we_o}), 64'd0);

    // m1 lock across three writes while m0 waits.
    m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 8'h30; m1_wdata = 32'hA0;
    push(M1, '0); push(M1, '0); push(M1, '0); push(M0, '0);
    for (int c = 1; c <= 11; c++) begin
      tick();
      check($sformatf("lk_m1_ack_c%0d", c), 64'(m1_ack_o), 64'(c == 2 || c == 5 || c == 8));
      check($sformatf("lk_m0_ack_c%0d", c), 64'(m0_ack_o), 64'(c == 10));
      check($sformatf("lk_to_c%0d", c), 64'(lock_to_o), 64'd0);
      if (c == 1 || c == 4 || c == 7)
        check($sformatf("lk_issue_m1_c%0d", c), 64'(f_waddr_o), 64'h30);
      if (c == 9) check("lk_issue_m0", 64'(f_waddr_o), 64'h40);
      if (c == 1) begin m0_req = 1; m0_we = 1; m0_addr = 8'h40; end
      if (c == 7) begin m1_lock = 0; m1_req = 0; end
      if (c == 9) m0_req = 0;
    end

    // Lock held idle until timeout; stale lock not honoured afterwards.
    m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 8'h34;
    push(M1, '0);
    for (int c = 1; c <= 24; c++) begin
      tick();
      check($sformatf("to_m1_ack_c%0d", c), 64'(m1_ack_o), 64'(c == 2 || c == 21));
      check($sformatf("to_m0_ack_c%0d", c), 64'(m0_ack_o), 64'(c == 19 || c == 23));
      check($sformatf("to_pulse_c%0d", c), 64'(lock_to_o), 64'(c == 17));
      if (c == 18) check("to_issue_m0", 64'(f_waddr_o), 64'h44);
      if (c == 20) check("to_issue_m1", 64'(f_waddr_o), 64'h38);
      if (c == 22) check("to_issue_m0_b", 64'(f_waddr_o), 64'h48);
      case (c)
        1:  begin m1_req = 0; m0_req = 1; m0_we = 1; m0_addr = 8'h44; push(M0, '0); end
        17: begin m1_req = 1; m1_addr = 8'h38; push(M1, '0); end
        18: m0_req = 0;
        20: begin m1_req = 0; m0_req = 1; m0_addr = 8'h48; push(M0, '0); end
        22: begin m0_req = 0; m1_lock = 0; end
        default: ;
      endcase
    end

    // Reset in the middle of a read ISSUE.
    m0_req = 1; m0_we = 0; m0_addr = 8'h24;
    tick();
    check("mrst_issue_rd", 64'(f_rd_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mrst_strobe_drop", 64'({f_rd_o, f_we_o}), 64'd0);
    check("mrst_noack", 64'({m0_ack_o, m1_ack_o}), 64'd0);
    tick();
    check("mrst_held", 64'({m0_ack_o, m1_ack_o, f_rd_o, f_waddr_o}), 64'd0);
    m0_we = 1; m0_addr = 8'h50;
    m1_req = 1; m1_we = 1; m1_addr = 8'h54;
    push(M0, '0); push(M1, '0);
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("post_m0_ack_c%0d", c), 64'(m0_ack_o), 64'(c == 2));
      check($sformatf("post_m1_ack_c%0d", c), 64'(m1_ack_o), 64'(c == 4));
      if (c == 1) check("post_first_tie_m0", 64'(f_waddr_o), 64'h50);
      if (c == 3) check("post_second_m1", 64'(f_waddr_o), 64'h54);
      if (c == 2) m0_req = 0;
      if (c == 3) m1_req = 0;
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
